wavefront_mask_sequencer: RTL and testbench

Generates the WIDTH-bit processing-element activation mask for the LCMV systolic array. On each `start` it fills a wavefront of ones in from the MSB, holds the full mask for a programmable number of cycles, then drains zeros in from the MSB. It sits between the classifier control FSM and the array's per-PE enables. It owns its mask register and handles stall and abort.

---
 rtl/wavefront_mask_sequencer.sv | 124 ++++++++++++
 tb/tb_wavefront_mask_sequencer.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wavefront_mask_sequencer.sv
// PE activation mask sequencer: fills ones in from the MSB, holds the full mask for a
// programmable number of cycles, then drains zeros in from the MSB.
module wavefront_mask_sequencer #(
    parameter int unsigned WIDTH  = 5,
    parameter int unsigned HOLD_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [HOLD_W-1:0] hold_len,
    input  logic              stall,
    input  logic              abort,
    output logic [WIDTH-1:0]  mask,
    output logic [1:0]        phase,
    output logic              busy,
    output logic              done
);

    localparam int unsigned StepW = $clog2(WIDTH + 1);
    localparam logic [StepW-1:0] StepOne  = StepW'(1);
    localparam logic [StepW-1:0] StepLast = StepW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StFill  = 2'b01,
        StHold  = 2'b10,
        StDrain = 2'b11
    } state_e;

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    mask_q, mask_d;
    logic [StepW-1:0]    step_q, step_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [HOLD_W-1:0]   hold_len_q, hold_len_d;
    logic                done_q, done_d;

    // One bit wider than the counter so hold_len = 2^HOLD_W-1 compares without wrapping.
    logic [HOLD_W:0]     hold_cnt_inc;

    assign hold_cnt_inc = {1'b0, hold_cnt_q} + {{HOLD_W{1'b0}}, 1'b1};

    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        step_d     = step_q;
        hold_cnt_d = hold_cnt_q;
        hold_len_d = hold_len_q;
        done_d     = 1'b0;

        if (abort) begin
            state_d    = StIdle;
            mask_d     = '0;
            step_d     = '0;
            hold_cnt_d = '0;
        end else if (stall && (state_q != StIdle)) begin
            // Frozen: every register keeps its value, done stays low.
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        mask_d     = {1'b1, mask_q[WIDTH-1:1]};
                        hold_len_d = hold_len;
                        step_d     = StepOne;
                        state_d    = StFill;
                    end
                end
                StFill: begin
                    mask_d = {1'b1, mask_q[WIDTH-1:1]};
                    step_d = step_q + StepOne;
                    // step_q counts the ones already present; this edge completes the mask.
                    if (step_q == StepLast) begin
                        state_d = (hold_len_q != '0) ? StHold : StDrain;
                    end
                end
                StHold: begin
                    if (hold_cnt_inc == {1'b0, hold_len_q}) begin
                        state_d    = StDrain;
                        hold_cnt_d = '0;
                    end else begin
                        hold_cnt_d = hold_cnt_inc[HOLD_W-1:0];
                    end
                end
                StDrain: begin
                    mask_d = {1'b0, mask_q[WIDTH-1:1]};
                    step_d = step_q - StepOne;
                    if (step_q == StepOne) begin
                        state_d = StIdle;
                        step_d  = '0;
                        done_d  = 1'b1;
                    end
                end
                default: begin
                    state_d = StIdle;
                    mask_d  = '0;
                    step_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            mask_q     <= '0;
            step_q     <= '0;
            hold_cnt_q <= '0;
            hold_len_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            step_q     <= step_d;
            hold_cnt_q <= hold_cnt_d;
            hold_len_q <= hold_len_d;
            done_q     <= done_d;
        end
    end

    assign mask  = mask_q;
    assign phase = state_q;
    assign busy  = (state_q != StIdle);
    assign done  = done_q;

endmodule

// File: tb/tb_wavefront_mask_sequencer.sv
// Directed self-checking bench for wavefront_mask_sequencer (WIDTH=5), with a second
// HOLD_W=3 instance for the long-hold scenario.
module tb_wavefront_mask_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] hold_len;
    logic       stall;
    logic       abort;
    logic [4:0] mask;
    logic [1:0] phase;
    logic       busy;
    logic       done;

    logic       start3;
    logic [2:0] hold3;
    logic [4:0] mask3;
    logic [1:0] phase3;
    logic       busy3;
    logic       done3;

    int errors = 0;
    int checks = 0;
    logic mon_en = 1'b0;
    logic [4:0] inv_m;
    logic therm_ok;

    wavefront_mask_sequencer #(.WIDTH(5), .HOLD_W(8)) u_dut (
        .clk(clk), .rst(rst), .start(start), .hold_len(hold_len), .stall(stall),
        .abort(abort), .mask(mask), .phase(phase), .busy(busy), .done(done)
    );

    wavefront_mask_sequencer #(.WIDTH(5), .HOLD_W(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start3), .hold_len(hold3), .stall(stall),
        .abort(abort), .mask(mask3), .phase(phase3), .busy(busy3), .done(done3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Thermometer invariant, sampled mid-cycle.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            inv_m = ~mask;
            case (phase)
                2'b00:   therm_ok = (mask == 5'd0);
                2'b11:   therm_ok = (mask != 5'd0) && ((mask & (mask + 5'd1)) == 5'd0);
                default: therm_ok = (mask != 5'd0) && ((inv_m & (inv_m + 5'd1)) == 5'd0);
            endcase
            checks++;
            if (!therm_ok) begin
                errors++;
                $display("FAIL thermometer: mask=%b phase=%0d", mask, phase);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        hold_len = 8'd3;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (mask !== 5'd0 || phase !== 2'd0 || busy !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL reset[%0d]: mask=%b phase=%0d busy=%b done=%b, want all zero",
                         i, mask, phase, busy, done);
            end
        end
        rst = 1'b0;
        start = 1'b0;
        tick();
        checks++;
        if (mask !== 5'd0 || phase !== 2'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL post_reset: mask=%b phase=%0d busy=%b done=%b, want all zero",
                     mask, phase, busy, done);
        end
        mon_en = 1'b1;
    endtask

    task automatic test_basic();
        logic [4:0] em [12];
        logic [1:0] ep [12];
        em = '{5'b10000, 5'b11000, 5'b11100, 5'b11110, 5'b11111, 5'b11111,
               5'b11111, 5'b01111, 5'b00111, 5'b00011, 5'b00001, 5'b00000};
        ep = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0};
        hold_len = 8'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i > 0) tick();
            checks++;
            if (mask !== em[i] || phase !== ep[i] || busy !== (i < 11) || done !== (i == 11)) begin
                errors++;
                $display("FAIL basic[%0d]: mask=%b phase=%0d busy=%b done=%b, want %b %0d %b %b",
                         i, mask, phase, busy, done, em[i], ep[i], (i < 11), (i == 11));
            end
        end
        tick();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_after: done=%b busy=%b, want 0 0", done, busy);
        end
    endtask

    task automatic test_zero_hold();
        logic [4:0] em [10];
        logic [1:0] ep [10];
        em = '{5'b10000, 5'b11000, 5'b11100, 5'b11110, 5'b11111,
               5'b01111, 5'b00111, 5'b00011, 5'b00001, 5'b00000};
        ep = '{2'd1, 2'd1, 2'd1, 2'd1, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0};
        hold_len = 8'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i > 0) tick();
            checks++;
            if (mask !== em[i] || phase !== ep[i] || done !== (i == 9)) begin
                errors++;
                $display("FAIL zero_hold[%0d]: mask=%b phase=%0d done=%b, want %b %0d %b",
                         i, mask, phase, done, em[i], ep[i], (i == 9));
            end
        end
        tick();
    endtask

    task automatic test_stall();
        int e;
        int full;
        hold_len = 8'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if (mask !== 5'b11100 || phase !== 2'd1 || busy !== 1'b1) begin
                errors++;
                $display("FAIL stall_hold[%0d]: mask=%b phase=%0d busy=%b, want 11100 1 1",
                         i, mask, phase, busy);
            end
        end
        stall = 1'b0;
        e = 4;
        full = 0;
        do begin
            tick();
            e++;
            if (mask === 5'b11111) full++;
        end while (done !== 1'b1 && e < 40);
        checks++;
        if (e !== 13 || full !== 3) begin
            errors++;
            $display("FAIL stall_done: done at edge %0d full=%0d, want edge 13 full 3", e, full);
        end
        tick();
    endtask

    task automatic test_abort();
        int e;
        int full;
        hold_len = 8'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (8) tick();
        checks++;
        if (mask !== 5'b00111 || phase !== 2'd3) begin
            errors++;
            $display("FAIL abort_pre: mask=%b phase=%0d, want 00111 3", mask, phase);
        end
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (mask !== 5'd0 || phase !== 2'd0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort: mask=%b phase=%0d busy=%b done=%b, want 0 0 0 0",
                     mask, phase, busy, done);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (done !== 1'b0 || mask !== 5'd0) begin
                errors++;
                $display("FAIL abort_quiet[%0d]: done=%b mask=%b, want 0 00000", i, done, mask);
            end
        end
        // Abort outranks stall.
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        stall = 1'b1;
        abort = 1'b1;
        tick();
        stall = 1'b0;
        abort = 1'b0;
        checks++;
        if (mask !== 5'd0 || phase !== 2'd0 || done !== 1'b0) begin
            errors++;
            $display("FAIL abort_stall: mask=%b phase=%0d done=%b, want 0 0 0", mask, phase, done);
        end
        start = 1'b1;
        tick();
        start = 1'b0;
        e = 0;
        full = 0;
        do begin
            tick();
            e++;
            if (mask === 5'b11111) full++;
        end while (done !== 1'b1 && e < 40);
        checks++;
        if (e !== 11 || full !== 3) begin
            errors++;
            $display("FAIL abort_rerun: done at edge %0d full=%0d, want edge 11 full 3", e, full);
        end
        tick();
    endtask

    task automatic test_start_handling();
        int e;
        int full;
        hold_len = 8'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        start = 1'b1;
        hold_len = 8'd0;
        tick();
        start = 1'b0;
        checks++;
        if (mask !== 5'b11110 || phase !== 2'd1) begin
            errors++;
            $display("FAIL start_busy: mask=%b phase=%0d, want 11110 1", mask, phase);
        end
        e = 3;
        full = 0;
        do begin
            tick();
            e++;
            if (mask === 5'b11111) full++;
        end while (done !== 1'b1 && e < 40);
        checks++;
        if (e !== 11 || full !== 3) begin
            errors++;
            $display("FAIL start_busy_done: done at edge %0d full=%0d, want edge 11 full 3",
                     e, full);
        end
        // Back-to-back: start in the done cycle.
        start = 1'b1;
        hold_len = 8'd0;
        tick();
        start = 1'b0;
        checks++;
        if (mask !== 5'b10000 || phase !== 2'd1 || busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back: mask=%b phase=%0d busy=%b done=%b, want 10000 1 1 0",
                     mask, phase, busy, done);
        end
        e = 0;
        do begin
            tick();
            e++;
        end while (done !== 1'b1 && e < 40);
        checks++;
        if (e !== 9) begin
            errors++;
            $display("FAIL back_to_back_done: done at edge %0d, want edge 9", e);
        end
        // Start with stall high in IDLE is still accepted; the stall then freezes FILL.
        start = 1'b1;
        stall = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if (mask !== 5'b10000 || phase !== 2'd1) begin
            errors++;
            $display("FAIL start_stall: mask=%b phase=%0d, want 10000 1", mask, phase);
        end
        tick();
        stall = 1'b0;
        checks++;
        if (mask !== 5'b10000) begin
            errors++;
            $display("FAIL start_stall_hold: mask=%b, want 10000", mask);
        end
        e = 1;
        do begin
            tick();
            e++;
        end while (done !== 1'b1 && e < 40);
        checks++;
        if (e !== 10) begin
            errors++;
            $display("FAIL start_stall_done: done at edge %0d, want edge 10", e);
        end
        tick();
    endtask

    task automatic test_long_hold();
        int e;
        int full;
        hold3 = 3'd7;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        e = 0;
        full = 0;
        do begin
            tick();
            e++;
            if (e == 6) hold3 = 3'd1;
            if (mask3 === 5'b11111) full++;
        end while (done3 !== 1'b1 && e < 40);
        checks++;
        if (e !== 16 || full !== 8) begin
            errors++;
            $display("FAIL long_hold: done at edge %0d full=%0d, want edge 16 full 8", e, full);
        end
        checks++;
        if (mask3 !== 5'd0 || busy3 !== 1'b0 || phase3 !== 2'd0) begin
            errors++;
            $display("FAIL long_hold_end: mask=%b busy=%b phase=%0d, want 0 0 0",
                     mask3, busy3, phase3);
        end
        tick();
    endtask

    task automatic test_max_hold();
        int e;
        int full;
        hold_len = 8'd255;
        start = 1'b1;
        tick();
        start = 1'b0;
        e = 0;
        full = 0;
        do begin
            tick();
            e++;
            if (mask === 5'b11111) full++;
        end while (done !== 1'b1 && e < 400);
        checks++;
        if (e !== 264 || full !== 256) begin
            errors++;
            $display("FAIL max_hold: done at edge %0d full=%0d, want edge 264 full 256", e, full);
        end
        tick();
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        hold_len = 8'd0;
        stall = 1'b0;
        abort = 1'b0;
        start3 = 1'b0;
        hold3 = 3'd0;
        test_reset();
        test_basic();
        test_zero_hold();
        test_stall();
        test_abort();
        test_start_handling();
        test_long_hold();
        test_max_hold();
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
